// File: rtl/register_file_pkg.sv
// Shared definitions for the dual-bank MIPS register file: default widths,
// register count, the hardwired zero register and the bank-select encoding.
package register_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int NUM_REGS           = 32;
    localparam logic [4:0] ZERO_REG   = 5'd0;

    typedef enum logic {
        BANK_INT   = 1'b0,
        BANK_FLOAT = 1'b1
    } bank_e;

    localparam int NUM_BANKS = 2;

    // A bank accepts a write only when the shared enable is up and it is the selected bank.
    function automatic logic bankWriteEn(input logic regWrite, input logic floatSel,
                                         input bank_e bank);
        return regWrite && (bank_e'(floatSel) == bank);
    endfunction

endpackage

// File: rtl/register_file_reg_bank.sv
// One register bank: 2^ADDR_WIDTH words, synchronous clear, one write port,
// two combinational read ports; register 0 is hardwired to zero.
module reg_bank
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  writeEn,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readAddr1,
    input  logic [ADDR_WIDTH-1:0] readAddr2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  writeOk;

    assign writeOk = writeEn && (writeAddr != ZERO_ADDR);

    // Reset wins over a write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (writeOk) begin
            regs[writeAddr] <= writeData;
        end
    end

    // The zero register is forced on read as well, so it never depends on storage contents.
    assign readData1 = (readAddr1 == ZERO_ADDR) ? '0 : regs[readAddr1];
    assign readData2 = (readAddr2 == ZERO_ADDR) ? '0 : regs[readAddr2];

endmodule

// File: rtl/register_file.sv
// Dual-bank (integer / floating-point) MIPS register file; the float bit
// selects the bank for both reads and the write.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    input  logic                  float,
    output logic [DATA_WIDTH-1:0] dataOut1,
    output logic [DATA_WIDTH-1:0] dataOut2
);

    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bankRd1;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bankRd2;
    logic [NUM_BANKS-1:0]                 bankWe;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
        localparam bank_e BANK = bank_e'(b);

        assign bankWe[b] = bankWriteEn(regWrite, float, BANK);

        reg_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) uBank (
            .clk       (clk),
            .reset     (reset),
            .writeEn   (bankWe[b]),
            .writeAddr (writeReg),
            .writeData (writeData),
            .readAddr1 (readReg1),
            .readAddr2 (readReg2),
            .readData1 (bankRd1[b]),
            .readData2 (bankRd2[b])
        );
    end

    // Output mux follows float combinationally, so a bank switch is visible at once.
    assign dataOut1 = bankRd1[float];
    assign dataOut2 = bankRd2[float];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vectors with literal expectations plus a
// two-bank array model compared against both read ports on every falling edge.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] writeData;
    logic        regWrite;
    logic        float;
    logic [31:0] dataOut1, dataOut2;

    int checks = 0;
    int errors = 0;

    register_file dut (
        .clk       (clk),
        .reset     (reset),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .writeReg  (writeReg),
        .writeData (writeData),
        .regWrite  (regWrite),
        .float     (float),
        .dataOut1  (dataOut1),
        .dataOut2  (dataOut2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: bank index 0 = integer, 1 = float; entry 0 is never written.
    logic [31:0] mdl [2][32];
    bit          modelValid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int bk = 0; bk < 2; bk++)
                for (int a = 0; a < 32; a++) mdl[bk][a] = 32'h0;
            modelValid = 1'b1;
        end else if (regWrite && writeReg != 5'd0) begin
            mdl[float][writeReg] = writeData;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checks++;
            if (dataOut1 !== mdl[float][readReg1]) begin
                errors++;
                $display("FAIL model_port1 t=%0t bank=%0d addr=%0d got=%h exp=%h",
                         $time, float, readReg1, dataOut1, mdl[float][readReg1]);
            end
            checks++;
            if (dataOut2 !== mdl[float][readReg2]) begin
                errors++;
                $display("FAIL model_port2 t=%0t bank=%0d addr=%0d got=%h exp=%h",
                         $time, float, readReg2, dataOut2, mdl[float][readReg2]);
            end
        end
    end

    task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Inputs move 2 time units after a rising edge; literal checks land 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setup(input logic f, input logic [4:0] wr, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2, input logic we);
        float = f; writeReg = wr; writeData = d;
        readReg1 = r1; readReg2 = r2; regWrite = we;
        #1;
    endtask

    task automatic doWrite(input logic f, input logic [4:0] wr, input logic [31:0] d,
                           input logic [4:0] r1, input logic [4:0] r2);
        setup(f, wr, d, r1, r2, 1'b1);
        tick();
        regWrite = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; regWrite = 1'b0; float = 1'b0;
        readReg1 = 5'd1; readReg2 = 5'd2; writeReg = 5'd0; writeData = 32'h0;
        tick();
        reset = 1'b0;
        #1;
        expect32("reset_out1", dataOut1, 32'h0);
        expect32("reset_out2", dataOut2, 32'h0);

        // Integer write r1; no bypass before the edge.
        setup(1'b0, 5'd1, 32'h0000_0044, 5'd1, 5'd2, 1'b1);
        expect32("r1_before_edge", dataOut1, 32'h0);
        expect32("r2_before_edge", dataOut2, 32'h0);
        tick(); regWrite = 1'b0; #1;
        expect32("r1_after_write", dataOut1, 32'h0000_0044);
        expect32("r2_untouched", dataOut2, 32'h0);

        setup(1'b0, 5'd2, 32'hFFFF_FFFF, 5'd1, 5'd2, 1'b1);
        expect32("r2_old_value", dataOut2, 32'h0);
        tick(); regWrite = 1'b0; #1;
        expect32("r1_kept", dataOut1, 32'h0000_0044);
        expect32("r2_after_write", dataOut2, 32'hFFFF_FFFF);

        doWrite(1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd2);
        expect32("r0_hardwired", dataOut1, 32'h0);
        expect32("r2_via_port2", dataOut2, 32'hFFFF_FFFF);

        setup(1'b0, 5'd0, 32'h0, 5'd2, 5'd2, 1'b0);
        expect32("same_addr_p1", dataOut1, 32'hFFFF_FFFF);
        expect32("same_addr_p2", dataOut2, 32'hFFFF_FFFF);

        // Float bank isolation, then an immediate switch back to integer.
        doWrite(1'b1, 5'd1, 32'hF0F0_F0F0, 5'd1, 5'd2);
        expect32("f1_after_write", dataOut1, 32'hF0F0_F0F0);
        expect32("f2_zero", dataOut2, 32'h0);
        float = 1'b0;
        #1;
        expect32("switch_int_r1", dataOut1, 32'h0000_0044);
        expect32("switch_int_r2", dataOut2, 32'hFFFF_FFFF);

        doWrite(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        expect32("f0_hardwired", dataOut1, 32'h0);
        doWrite(1'b1, 5'd31, 32'h3333_3333, 5'd30, 5'd31);
        expect32("f30_zero", dataOut1, 32'h0);
        expect32("f31_written", dataOut2, 32'h3333_3333);
        float = 1'b0;
        #1;
        expect32("r31_still_zero", dataOut2, 32'h0);

        // Reset beats a write on the same edge.
        setup(1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0; regWrite = 1'b0;
        #1;
        expect32("r5_reset_priority", dataOut1, 32'h0);
        for (int bk = 0; bk < 2; bk++) begin
            for (int a = 0; a < 32; a += 2) begin
                float = bk[0]; readReg1 = 5'(a); readReg2 = 5'(a + 1);
                #1;
                expect32("post_reset_p1", dataOut1, 32'h0);
                expect32("post_reset_p2", dataOut2, 32'h0);
            end
        end

        // Seed a few values, then hold regWrite low while everything else moves.
        doWrite(1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd8);
        doWrite(1'b1, 5'd8, 32'h8765_4321, 5'd7, 5'd8);
        expect32("f8_written", dataOut2, 32'h8765_4321);
        expect32("f7_zero", dataOut1, 32'h0);
        for (int i = 0; i < 24; i++) begin
            setup(1'($urandom), 5'($urandom), $urandom, 5'($urandom_range(6, 9)),
                  5'($urandom), 1'b0);
            tick();
        end
        setup(1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b0);
        expect32("r7_hold", dataOut1, 32'h1234_5678);
        expect32("r8_hold", dataOut2, 32'h0);
        float = 1'b1;
        #1;
        expect32("f8_hold", dataOut2, 32'h8765_4321);

        // Mixed traffic across both banks, checked by the model each cycle.
        for (int i = 0; i < 200; i++) begin
            setup(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom),
                  1'($urandom));
            tick();
        end
        regWrite = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
